uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

- Receive-side byte buffer sitting directly downstream of the UART receiver.
- Captures each byte the receiver presents with its one-cycle `data_ready` pulse and stores it in a circular FIFO.
- Hands bytes to the consumer (command parser / host interface) over a valid/ready handshake with first-word-fall-through output.
- Reports fill level, almost-full and overflow, so a slow consumer never stalls the receiver; bytes arriving on a full FIFO are dropped and flagged.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, minimum 2.
- `ALMOST_FULL`, 12: `o_almost_full` asserts when count >= this value; range 1..DEPTH.
- `clk` input 1: system clock, rising edge; same clock as the receiver.
- `rst_n` input 1: asynchronous, active-low reset.
- `data_in` input 8: byte from the receiver.
- `data_ready` input 1: one-cycle strobe; `data_in` is valid while high.
- `o_data` output 8: byte at the FIFO head.
- `o_valid` output 1: head byte present (FIFO not empty).
- `i_ready` input 1: consumer accepts the head byte this cycle.
- `o_count` output log2(DEPTH)+1: stored bytes, 0..DEPTH.
- `o_full` output 1: count == DEPTH.
- `o_almost_full` output 1: count >= ALMOST_FULL.
- `o_overflow` output 1: a byte was dropped (see Configuration).
- `i_ovf_clr` input 1: clears the sticky overflow flag.

## Operation
- **Storage**
  - DEPTH x 8 register array.
  - Write pointer `wr_ptr` and read pointer `rd_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Count register log2(DEPTH)+1 bits; full and empty derive from count only.
- **Push**: `data_ready`=1 and (not full, or pop in the same cycle).
  - Write `data_in` to `mem[wr_ptr]`; `wr_ptr`++.
- **Pop**: `o_valid`=1 and `i_ready`=1; `rd_ptr`++.
- **Count**: +1 on push only, -1 on pop only, unchanged on both or neither.
- **Full with simultaneous pop**: push accepted, count stays DEPTH, no overflow.
- **Full without pop**: byte dropped; pointers and count unchanged; overflow event raised.
- **Empty with push**: a pop is impossible because `o_valid`=0; the byte becomes the head next cycle.
- **Output path**: `o_data` = `mem[rd_ptr]`, combinational from storage.
  - `o_data` is don't-care while `o_valid`=0; the bench must not check it then.
- `i_ready` with `o_valid`=0 is ignored.
- **No state machine**: behaviour is fully defined by pointers, count and the overflow flag.

## Timing
- **Reset (async assert, sync release)**
  - Pointers = 0, count = 0.
  - `o_valid`=0, `o_full`=0, `o_almost_full`=0, `o_overflow`=0.
  - Storage contents are not reset.
  - Reset mid-operation discards all stored bytes immediately.
- **Latency**: `data_ready` sampled high at edge N gives `o_valid`=1 and `o_data`=byte after edge N (visible cycle N+1).
- **Throughput**: one push and one pop per cycle.
- **Flags**: `o_count`, `o_full`, `o_almost_full` are registered and update at the same edge as the pointers.
- **Upstream assumptions**
  - Strobes may be back-to-back on every cycle; no assumption of receiver spacing.
  - No backpressure to the receiver exists.

## Configuration
- Macro `UART_RX_FIFO_STICKY_OVF_EN`.
- **Defined**
  - `o_overflow` sets at the edge of a dropped byte and holds until `i_ovf_clr`=1 is sampled.
  - If a drop and `i_ovf_clr` occur in the same cycle, set wins.
- **Undefined**
  - `o_overflow` is a one-cycle registered pulse, high in the cycle after each drop.
  - `i_ovf_clr` is ignored.

## Test plan
- **Single byte**: reset; strobe 0x55; `i_ready`=0 -> next cycle `o_valid`=1, `o_data`=0x55, `o_count`=1; then `i_ready`=1 for one cycle -> `o_valid`=0, `o_count`=0.
- **Fill and drop**: strobe 0x00..0x10 back-to-back (17 bytes), `i_ready`=0, DEPTH=16.
  - `o_almost_full` rises after the 12th byte; `o_full` after the 16th; the 17th (0x10) is dropped with `o_overflow`=1.
  - Draining then returns 0x00..0x0F in order.
- **Full plus simultaneous pop**: at count 16, assert `data_ready` (0xA5) and `i_ready` together -> count stays 16, no overflow, 0xA5 drained last.
- **Pointer wrap**: stream 40 bytes (0x30..0x57) with `i_ready` toggling 1,0 -> all 40 emerge in order, no overflow, count never exceeds DEPTH.
- **Reset mid-stream**: pulse `rst_n` low for half a cycle with 5 bytes stored -> `o_valid`=0, `o_count`=0 immediately; the next strobe (0x7E) is the head one cycle later.
- **Overflow flag behaviour**
  - With macro defined: flag holds after a drop until `i_ovf_clr` is pulsed.
  - Without macro: flag is a single-cycle pulse.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: strobe-driven push, FWFT valid/ready pop.
// Overflow flag is sticky when UART_RX_FIFO_STICKY_OVF_EN is defined, otherwise a one-cycle pulse.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               data_in,
    input  logic                     data_ready,
    output logic [7:0]               o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_almost_full,
    output logic                     o_overflow,
    input  logic                     i_ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          full, push, pop, drop;

    assign full    = (count == DEPTH_C);
    assign o_valid = (count != '0);
    assign pop     = o_valid && i_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a byte then.
    assign push    = data_ready && (!full || pop);
    assign drop    = data_ready && full && !pop;
    assign o_data  = mem[rd_ptr];
    assign o_count = count;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_full        <= 1'b0;
            o_almost_full <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count         <= count_nxt;
            o_full        <= (count_nxt == DEPTH_C);
            o_almost_full <= (count_nxt >= AF_C);
        end
    end

`ifdef UART_RX_FIFO_STICKY_OVF_EN
    // Set has priority over clear so a drop coinciding with a clear is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         o_overflow <= 1'b0;
        else if (drop)      o_overflow <= 1'b1;
        else if (i_ovf_clr) o_overflow <= 1'b0;
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = i_ovf_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_overflow <= 1'b0;
        else        o_overflow <= drop;
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, ALMOST_FULL=12); honours UART_RX_FIFO_STICKY_OVF_EN.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic [4:0] o_count;
    logic       o_full;
    logic       o_almost_full;
    logic       o_overflow;
    logic       i_ovf_clr;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(16), .ALMOST_FULL(12)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_ready(data_ready),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
        .o_full(o_full), .o_almost_full(o_almost_full), .o_overflow(o_overflow),
        .i_ovf_clr(i_ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_b;
        int exp_cnt, sent, cyc;

        rst_n = 1'b0; data_in = '0; data_ready = 1'b0; i_ready = 1'b0; i_ovf_clr = 1'b0;
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_full", o_full, 0);
        chk("rst_afull", o_almost_full, 0);
        chk("rst_ovf", o_overflow, 0);
        #10 rst_n = 1'b1;
        tick();

        // Single byte
        data_ready = 1'b1; data_in = 8'h55;
        tick();
        data_ready = 1'b0;
        chk("single_valid", o_valid, 1);
        chk("single_data", o_data, 8'h55);
        chk("single_count", o_count, 1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("single_pop_valid", o_valid, 0);
        chk("single_pop_count", o_count, 0);

        // Fill 0x00..0x10; the 17th byte is dropped
        for (int i = 0; i <= 16; i++) begin
            data_ready = 1'b1; data_in = 8'(i);
            tick();
            exp_cnt = (i + 1 > 16) ? 16 : i + 1;
            chk($sformatf("fill_count_%0d", i), o_count, exp_cnt);
            chk($sformatf("fill_afull_%0d", i), o_almost_full, exp_cnt >= 12);
            chk($sformatf("fill_full_%0d", i), o_full, exp_cnt == 16);
            chk($sformatf("fill_ovf_%0d", i), o_overflow, i == 16);
        end
        data_ready = 1'b0;
        tick();
`ifdef UART_RX_FIFO_STICKY_OVF_EN
        chk("ovf_hold", o_overflow, 1);
`else
        chk("ovf_pulse_end", o_overflow, 0);
`endif
        chk("full_count_hold", o_count, 16);

        // Drop coinciding with clear: flag must be high afterwards
        data_ready = 1'b1; data_in = 8'hEE; i_ovf_clr = 1'b1;
        tick();
        data_ready = 1'b0; i_ovf_clr = 1'b0;
        chk("ovf_set_wins", o_overflow, 1);
        chk("drop_count", o_count, 16);
        tick();
`ifdef UART_RX_FIFO_STICKY_OVF_EN
        chk("ovf_sticky", o_overflow, 1);
`else
        chk("ovf_single_cycle", o_overflow, 0);
`endif
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("ovf_cleared", o_overflow, 0);
        chk("head_before_simul", o_data, 8'h00);
        chk("valid_before_simul", o_valid, 1);

        // Full plus simultaneous pop
        data_ready = 1'b1; data_in = 8'hA5; i_ready = 1'b1;
        tick();
        data_ready = 1'b0; i_ready = 1'b0;
        chk("simul_count", o_count, 16);
        chk("simul_full", o_full, 1);
        chk("simul_ovf", o_overflow, 0);

        // Drain: 0x01..0x0F then 0xA5
        i_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            exp_b = (j < 15) ? 8'(j + 1) : 8'hA5;
            chk($sformatf("drain_valid_%0d", j), o_valid, 1);
            chk($sformatf("drain_data_%0d", j), o_data, exp_b);
            tick();
        end
        i_ready = 1'b0;
        chk("drained_valid", o_valid, 0);
        chk("drained_count", o_count, 0);
        chk("drained_full", o_full, 0);
        chk("drained_afull", o_almost_full, 0);

        // Pointer wrap: 40 bytes at 2/3 strobe rate, i_ready toggling 1,0
        sent = 0; cyc = 0;
        while ((sent < 40 || q.size() != 0) && cyc < 300) begin
            data_ready = (sent < 40) && (cyc % 3 != 0);
            data_in    = 8'(8'h30 + sent);
            i_ready    = (cyc % 2 == 0);
            chk("wrap_valid", o_valid, q.size() != 0);
            chk("wrap_count", o_count, q.size());
            chk("wrap_ovf", o_overflow, 0);
            if (i_ready && q.size() != 0) begin
                exp_b = q.pop_front();
                chk("wrap_data", o_data, exp_b);
            end
            if (data_ready) begin
                q.push_back(data_in);
                sent++;
            end
            tick();
            cyc++;
        end
        data_ready = 1'b0; i_ready = 1'b0;
        chk("wrap_all_sent", sent, 40);
        chk("wrap_done_in_budget", cyc < 300, 1);
        chk("wrap_end_count", o_count, 0);

        // Reset mid-stream with 5 bytes stored
        for (int i = 1; i <= 5; i++) begin
            data_ready = 1'b1; data_in = 8'(i);
            tick();
        end
        data_ready = 1'b0;
        chk("pre_rst_count", o_count, 5);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_count", o_count, 0);
        #3;
        rst_n = 1'b1;
        data_ready = 1'b1; data_in = 8'h7E;
        tick();
        data_ready = 1'b0;
        chk("postrst_valid", o_valid, 1);
        chk("postrst_data", o_data, 8'h7E);
        chk("postrst_count", o_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
